// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
//   Measures an external PWM waveform looped back into the FPGA. It reports the
//   period and the high time in CLK cycles, and flags a line that has stopped
//   toggling.
//
//   Optional feature macro: PWM_CAPTURE_DUTY_CALC_EN
//     When this macro is defined, the block adds a duty output with the value
//     floor(high_time*256/period), saturated to 255. A serial restoring divider
//     computes it. In this build, valid is delayed until the duty result is
//     ready, 9 cycles after the capture.
//
// Parameters
//   CNT_W        width of the period/high-time counters and outputs
//   SYNC_STAGES  flops in the pwm_in synchroniser (minimum 2)
//   TIMEOUT      cycles without a rising edge before the line is stuck
//                (must be <= 2^CNT_W-1)
//
// Ports
//   CLK         system clock, rising edge
//   RST         asynchronous active-high reset
//   pwm_in      asynchronous PWM input pin
//   period      cycles between the last two rising edges
//   high_time   cycles the line was high within that period
//   valid       one-cycle pulse marking a fresh measurement
//   stuck_high  no rising edge for TIMEOUT cycles, line high
//   stuck_low   no rising edge for TIMEOUT cycles, line low
//   duty        (feature build only) high_time*256/period, saturated to 255
// -----------------------------------------------------------------------------
module pwm_capture #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 65535
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             stuck_high,
`ifdef PWM_CAPTURE_DUTY_CALC_EN
  output logic             stuck_low,
  output logic [7:0]       duty
`else
  output logic             stuck_low
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic                   take;
  logic [CNT_W-1:0]       period_cnt;
  logic [CNT_W-1:0]       high_cnt;

  // ---------------------------------------------------------------------------
  // Input synchroniser and edge detect
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync <= '0;
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pwm_in};
      s_d  <= sync[SYNC_STAGES-1];
    end
  end

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  // A rise while measuring closes a full period; a rise from IDLE only arms.
  assign take = rise && (state == MEASURE);

  // ---------------------------------------------------------------------------
  // Measurement FSM. A rise takes priority over the timeout: when a rise and a
  // timeout occur in the same cycle, the capture proceeds as normal.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      period_cnt <= '0;
      high_cnt   <= '0;
      period     <= '0;
      high_time  <= '0;
      stuck_high <= 1'b0;
      stuck_low  <= 1'b0;
    end else begin
      if (rise) begin
        if (state == MEASURE) begin
          period    <= period_cnt;
          high_time <= high_cnt;
        end
        period_cnt <= CNT_ONE;
        high_cnt   <= CNT_ONE;
        stuck_high <= 1'b0;
        stuck_low  <= 1'b0;
        state      <= MEASURE;
      end else if (state == MEASURE) begin
        if (period_cnt == TIMEOUT_V) begin
          state      <= IDLE;
          period_cnt <= '0;
          high_cnt   <= '0;
          stuck_high <= s;
          stuck_low  <= ~s;
        end else begin
          if (period_cnt != CNT_MAX) begin
            period_cnt <= period_cnt + CNT_ONE;
          end
          if (s && (high_cnt != CNT_MAX)) begin
            high_cnt <= high_cnt + CNT_ONE;
          end
        end
      end
    end
  end

`ifdef PWM_CAPTURE_DUTY_CALC_EN
  // ---------------------------------------------------------------------------
  // Restoring divider: quotient = floor(high*256/period), 9 bits, MSB first.
  // high <= period, so the first step compares without a shift and yields the
  // integer bit. The following 8 steps shift the remainder left before they
  // compare. The divider loads on the capture edge and runs one step per
  // cycle. Completion is written before a new load, so a capture in the last
  // step cycle still reports the old result.
  // ---------------------------------------------------------------------------
  logic [CNT_W:0]   div_rem;
  logic [CNT_W-1:0] div_den;
  logic [7:0]       div_q;
  logic [3:0]       div_step;
  logic             ge;
  logic [CNT_W-1:0] trial;
  logic [CNT_W-1:0] rem_keep;
  logic [8:0]       q_final;

  always_comb begin
    ge       = (div_rem >= {1'b0, div_den});
    trial    = div_rem[CNT_W-1:0] - div_den;
    rem_keep = ge ? trial : div_rem[CNT_W-1:0];
    q_final  = {div_q, ge};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_rem  <= '0;
      div_den  <= '0;
      div_q    <= '0;
      div_step <= '0;
      duty     <= '0;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (div_step != 4'd0) begin
        div_rem  <= {rem_keep, 1'b0};
        div_q    <= q_final[7:0];
        div_step <= div_step - 4'd1;
        if (div_step == 4'd1) begin
          duty  <= q_final[8] ? 8'hFF : q_final[7:0];
          valid <= 1'b1;
        end
      end
      if (take) begin
        div_rem  <= {1'b0, high_cnt};
        div_den  <= period_cnt;
        div_q    <= '0;
        div_step <= 4'd9;
      end
    end
  end
`else
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid <= 1'b0;
    end else begin
      valid <= take;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// -----------------------------------------------------------------------------
// tb_pwm_capture
//   Self-checking bench for pwm_capture (TIMEOUT overridden to 200). The bench
//   drives PWM segments of known length. Each rising edge that closes a
//   segment no longer than TIMEOUT pushes that segment's length, high time,
//   and expected report cycle onto a scoreboard. A monitor pops one entry per
//   valid pulse.
// -----------------------------------------------------------------------------
module tb_pwm_capture;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned SS    = 2;
  localparam int unsigned TMO   = 200;
`ifdef PWM_CAPTURE_DUTY_CALC_EN
  localparam int unsigned DLY   = 9;
`else
  localparam int unsigned DLY   = 0;
`endif

  logic             CLK;
  logic             RST;
  logic             pwm_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             stuck_high;
  logic             stuck_low;
`ifdef PWM_CAPTURE_DUTY_CALC_EN
  logic [7:0]       duty;
`endif

  pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(SS), .TIMEOUT(TMO)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .pwm_in     (pwm_in),
    .period     (period),
    .high_time  (high_time),
    .valid      (valid),
    .stuck_high (stuck_high),
`ifdef PWM_CAPTURE_DUTY_CALC_EN
    .stuck_low  (stuck_low),
    .duty       (duty)
`else
    .stuck_low  (stuck_low)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int unsigned p;
    int unsigned h;
    logic [63:0] cyc;
  } exp_t;

  exp_t        q[$];
  logic [63:0] cyc = '0;
  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  int unsigned npushed    = 0;
  int unsigned nvalid     = 0;
  logic        armed      = 1'b0;
  int unsigned prev_p     = 0;
  int unsigned prev_h     = 0;
  int unsigned last_p     = 0;
  int unsigned last_h     = 0;

  always @(posedge CLK) cyc <= cyc + 64'd1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // The rising edge about to be driven closes the previous segment. That
  // segment is reported only if it started from an armed state and did not
  // outlast the timeout.
  task automatic close_segment();
    if (armed && prev_p <= TMO) begin
      q.push_back('{p: prev_p, h: prev_h, cyc: cyc + 64'(1 + SS + DLY)});
      npushed++;
      last_p = prev_p;
      last_h = prev_h;
    end
  endtask

  task automatic drive_period(input int unsigned p, input int unsigned h, input bit glitch);
    @(negedge CLK);
    close_segment();
    pwm_in = 1'b1;
    armed  = 1'b1;
    prev_p = p;
    prev_h = h;
    repeat (h) @(negedge CLK);
    pwm_in = 1'b0;
    for (int unsigned i = 0; i < p - h - 1; i++) begin
      if (glitch && i == (p - h - 1) / 2) begin
        // The pulse sits entirely between two rising CLK edges.
        @(posedge CLK);
        #2 pwm_in = 1'b1;
        #2 pwm_in = 1'b0;
      end
      @(negedge CLK);
    end
  endtask

  // Scoreboard monitor: sample 1 time unit after the active edge.
  always @(posedge CLK) begin
    #1;
    if (valid === 1'b1) begin
      nvalid++;
      if (q.size() == 0) begin
        check("spurious_valid", 64'(valid), 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("period", 64'(period), 64'(e.p));
        check("high_time", 64'(high_time), 64'(e.h));
        check("valid_cycle", cyc, e.cyc);
        check("high_le_period", 64'(high_time <= period), 64'd1);
`ifdef PWM_CAPTURE_DUTY_CALC_EN
        check("duty", 64'(duty), 64'((e.h * 256 / e.p > 255) ? 255 : e.h * 256 / e.p));
`endif
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_period"}, 64'(period), 64'd0);
    check({tag, "_high_time"}, 64'(high_time), 64'd0);
    check({tag, "_valid"}, 64'(valid), 64'd0);
    check({tag, "_stuck_high"}, 64'(stuck_high), 64'd0);
    check({tag, "_stuck_low"}, 64'(stuck_low), 64'd0);
`ifdef PWM_CAPTURE_DUTY_CALC_EN
    check({tag, "_duty"}, 64'(duty), 64'd0);
`endif
  endtask

  initial begin
    logic [63:0] t_rise;
    int unsigned p;
    int unsigned h;

    RST    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    check_all_zero("post_reset_idle");

    // Steady 30/100: the first rise only arms.
    repeat (5) drive_period(100, 30, 1'b0);
    // Duty change to 70/100.
    repeat (3) drive_period(100, 70, 1'b0);
    // Minimum pulse, then a pulse that the synchroniser never samples.
    repeat (3) drive_period(20, 1, 1'b0);
    drive_period(100, 30, 1'b1);
    check("glitch_hold_period", 64'(period), 64'd20);
    check("glitch_hold_high", 64'(high_time), 64'd1);
    drive_period(100, 30, 1'b0);

    // Randomised segments.
    for (int k = 0; k < 15; k++) begin
      p = $urandom_range(180, 10);
      h = $urandom_range(p - 1, 1);
      drive_period(p, h, 1'b0);
    end

    // The rise lands exactly on the timeout cycle: the rise wins.
    drive_period(200, 50, 1'b0);
    drive_period(200, 199, 1'b0);
    // One cycle longer than the timeout: not reported, stuck_low is raised.
    drive_period(201, 50, 1'b0);
    drive_period(50, 20, 1'b0);
    check("after_long_stuck_low_cleared", 64'(stuck_low), 64'd0);
    drive_period(50, 20, 1'b0);

    // Line stuck high after a rise.
    @(negedge CLK);
    close_segment();
    pwm_in = 1'b1;
    armed  = 1'b1;
    prev_p = 100000;
    t_rise = cyc;
    repeat (195) @(negedge CLK);
    check("stuck_high_early", 64'(stuck_high), 64'd0);
    repeat (15) @(negedge CLK);
    check("stuck_high_set", 64'(stuck_high), 64'd1);
    check("stuck_high_low_flag", 64'(stuck_low), 64'd0);
    check("stuck_hold_period", 64'(period), 64'(last_p));
    check("stuck_hold_high", 64'(high_time), 64'(last_h));
    check("stuck_elapsed", cyc - t_rise, 64'd210);
    pwm_in = 1'b0;
    repeat (20) @(negedge CLK);
    check("stuck_high_holds_low_line", 64'(stuck_high), 64'd1);
    drive_period(50, 20, 1'b0);
    check("stuck_high_cleared", 64'(stuck_high), 64'd0);
    drive_period(60, 10, 1'b0);

    // Line stuck low: the segment started above outgrows the timeout.
    prev_p = 100000;
    repeat (200) @(negedge CLK);
    check("stuck_low_set", 64'(stuck_low), 64'd1);
    check("stuck_low_high_flag", 64'(stuck_high), 64'd0);
    check("stuck_low_hold_period", 64'(period), 64'(last_p));

    // Asynchronous reset in the low phase of a period.
    repeat (3) drive_period(100, 30, 1'b0);
    @(negedge CLK);
    close_segment();
    pwm_in = 1'b1;
    armed  = 1'b1;
    prev_p = 100;
    prev_h = 30;
    repeat (30) @(negedge CLK);
    pwm_in = 1'b0;
    repeat (30) @(negedge CLK);
    check("queue_drained_before_reset", 64'(q.size()), 64'd0);
    #3 RST = 1'b1;
    #1 check_all_zero("async_reset");
    #3 RST = 1'b0;
    armed = 1'b0;
    repeat (20) @(negedge CLK);
    check("reset_no_valid", 64'(valid), 64'd0);
    drive_period(100, 30, 1'b0);
    drive_period(80, 45, 1'b0);
    drive_period(50, 20, 1'b0);

    repeat (20) @(negedge CLK);
    check("scoreboard_empty", 64'(q.size()), 64'd0);
    check("valid_count", 64'(nvalid), 64'(npushed));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
